// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin scheduler that shares one 4-bit parallel_adder
// between two requesters. A W-bit addition (W = 4*NIBBLES) is done one nibble
// per cycle, LSB nibble first, with the carry held in a register between cycles.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   req0, a0, b0, cin0    - requester 0 request and operands
//   req1, a1, b1, cin1    - requester 1 request and operands
//   grant0, grant1        - one-cycle pulse: that requester's operands are latched
//   busy                  - high while an operation is in ADD or DONE
//   sum, carryOut         - result of the last completed operation (held)
//   done                  - one-cycle pulse: sum/carryOut hold a new result
//   doneId                - requester that owns the current result

// parallel_adder: 4-bit combinational adder with carry in/out.
module parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carryIn,
  output logic [3:0] sum,
  output logic       carryOut
);
  assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, carryIn};
endmodule

module adder_scheduler #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic         grant0,
  output logic         grant1,
  output logic         busy,
  output logic [W-1:0] sum,
  output logic         carryOut,
  output logic         done,
  output logic         doneId
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [W-1:0]    op_a_q,   op_a_d;
  logic [W-1:0]    op_b_q,   op_b_d;
  logic [W-1:0]    part_q,   part_d;
  logic            carry_q,  carry_d;
  logic [IDXW-1:0] idx_q,    idx_d;
  logic            last_q,   last_d;
  logic            gid_q,    gid_d;
  logic [W-1:0]    sum_q,    sum_d;
  logic            cout_q,   cout_d;
  logic            done_q,   done_d;
  logic            did_q,    did_d;
  logic            grant0_q, grant0_d;
  logic            grant1_q, grant1_d;
  logic            busy_q,   busy_d;

  logic [3:0]      add_a_s;
  logic [3:0]      add_b_s;
  logic [3:0]      add_sum_s;
  logic            add_co_s;
  logic            win_s;

  // The shared adder always sees the current nibble; its result is only
  // consumed in ADD, so driving it in other states is harmless.
  assign add_a_s = op_a_q[{idx_q, 2'b00} +: 4];
  assign add_b_s = op_b_q[{idx_q, 2'b00} +: 4];

  parallel_adder u_adder (
    .a        (add_a_s),
    .b        (add_b_s),
    .carryIn  (carry_q),
    .sum      (add_sum_s),
    .carryOut (add_co_s)
  );

  // Arbitration: a lone requester wins; on contention the requester that was
  // not granted last time wins.
  always_comb begin
    if (req0 && req1) begin
      win_s = ~last_q;
    end else begin
      win_s = req1;
    end
  end

  // Next-state and datapath logic for the IDLE/ADD/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    part_d   = part_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    last_d   = last_q;
    gid_d    = gid_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    did_d    = did_q;
    done_d   = 1'b0;
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d  = S_ADD;
          op_a_d   = win_s ? a1 : a0;
          op_b_d   = win_s ? b1 : b0;
          carry_d  = win_s ? cin1 : cin0;
          idx_d    = {IDXW{1'b0}};
          last_d   = win_s;
          gid_d    = win_s;
          grant0_d = ~win_s;
          grant1_d = win_s;
          busy_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        busy_d                    = 1'b1;
        part_d[{idx_q, 2'b00} +: 4] = add_sum_s;
        carry_d                   = add_co_s;
        idx_d                     = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          // Publish the completed result; partials never reach sum.
          state_d = S_DONE;
          sum_d   = part_d;
          cout_d  = add_co_s;
          did_d   = gid_q;
          done_d  = 1'b1;
          idx_d   = {IDXW{1'b0}};
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_a_q   <= {W{1'b0}};
      op_b_q   <= {W{1'b0}};
      part_q   <= {W{1'b0}};
      carry_q  <= 1'b0;
      idx_q    <= {IDXW{1'b0}};
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      sum_q    <= {W{1'b0}};
      cout_q   <= 1'b0;
      did_q    <= 1'b0;
      done_q   <= 1'b0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      part_q   <= part_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      did_q    <= did_d;
      done_q   <= done_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      busy_q   <= busy_d;
    end
  end

  assign grant0   = grant0_q;
  assign grant1   = grant1_q;
  assign busy     = busy_q;
  assign sum      = sum_q;
  assign carryOut = cout_q;
  assign done     = done_q;
  assign doneId   = did_q;

endmodule
